// File: rtl/inner_product_if.sv
// inner_product_if: upstream/downstream valid-ready bundle for the inner-product stage
interface inner_product_if #(
  parameter int N_ROW = 4,
  parameter int RIJ_W = 20
);
  logic                   i_valid;
  logic                   o_ready;
  logic [48*N_ROW-1:0]    in_h;
  logic [48*N_ROW-1:0]    e;
  logic                   o_valid;
  logic                   i_ready;
  logic [48*N_ROW-1:0]    out_h;
  logic [48*N_ROW-1:0]    out_e;
  logic [2*RIJ_W-1:0]     Rij;
  modport slave (
    input  i_valid, in_h, e, i_ready,
    output o_ready, o_valid, out_h, out_e, Rij
  );
  modport master (
    output i_valid, in_h, e, i_ready,
    input  o_ready, o_valid, out_h, out_e, Rij
  );
endinterface

// File: rtl/inner_product.sv
// inner_product: Rij = conj(e)^T * h using one shared complex MAC, one row per cycle.
// Define IP_ROUND_EN to round half up before the shift; otherwise truncate toward -inf.
module inner_product #(
  parameter int N_ROW      = 4,
  parameter int RIJ_W      = 20,
  parameter int FRAC_SHIFT = 22
) (
  input  logic           i_clk,
  input  logic           i_rst,
  inner_product_if.slave bus
);
  localparam int KW = $clog2(N_ROW + 1);
  localparam int SW = 51 - FRAC_SHIFT;
  localparam logic signed [SW-1:0] SMAX = SW'((2 ** (RIJ_W - 1)) - 1);
  localparam logic signed [SW-1:0] SMIN = SW'(-(2 ** (RIJ_W - 1)));
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t                    state_q, state_d;
  logic [KW-1:0]             k_q, k_d;
  logic signed [49:0]        acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [48*N_ROW-1:0]       h_q, h_d, e_q, e_d;
  logic [2*RIJ_W-1:0]        rij_q, rij_d;
  logic                      accept, mac_en, last;
  logic [KW-1:0]             row;
  logic signed [23:0]        a, b, hr, hi;
  logic signed [47:0]        p_ar, p_bi, p_ai, p_br;
  function automatic logic [RIJ_W-1:0] conv(input logic signed [49:0] acc);
    logic signed [50:0]   r;
    logic signed [SW-1:0] s;
`ifdef IP_ROUND_EN
    r = 51'(acc) + (51'sd1 <<< (FRAC_SHIFT - 1));
`else
    r = 51'(acc);
`endif
    s = SW'(r >>> FRAC_SHIFT);
    return (s > SMAX) ? RIJ_W'(SMAX) : (s < SMIN) ? RIJ_W'(SMIN) : RIJ_W'(s);
  endfunction
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      h_q      <= '0;
      e_q      <= '0;
      rij_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      h_q      <= h_d;
      e_q      <= e_d;
      rij_q    <= rij_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (bus.i_valid ? MAC : IDLE) :
              (state_q == MAC)  ? (last ? OUT : MAC) :
                                  (bus.i_ready ? IDLE : OUT);
  end
  always_comb begin
    bus.o_ready = (state_q == IDLE);
    bus.o_valid = (state_q == OUT);
  end
  // k runs 0..N_ROW-1 accumulating rows; the extra k==N_ROW cycle converts the settled sums
  assign accept = bus.i_valid && (state_q == IDLE);
  assign last   = (k_q == KW'(N_ROW));
  assign mac_en = (state_q == MAC) && !last;
  assign row    = last ? '0 : k_q;
  assign a      = e_q[48*row +: 24];
  assign b      = e_q[48*row + 24 +: 24];
  assign hr     = h_q[48*row +: 24];
  assign hi     = h_q[48*row + 24 +: 24];
  assign p_ar   = a * hr;
  assign p_bi   = b * hi;
  assign p_ai   = a * hi;
  assign p_br   = b * hr;
  always_comb begin
    h_d      = accept ? bus.in_h : h_q;
    e_d      = accept ? bus.e : e_q;
    k_d      = accept ? '0 : mac_en ? k_q + 1'b1 : k_q;
    acc_re_d = accept ? '0 : mac_en ? acc_re_q + 50'(p_ar) + 50'(p_bi) : acc_re_q;
    acc_im_d = accept ? '0 : mac_en ? acc_im_q + 50'(p_ai) - 50'(p_br) : acc_im_q;
    rij_d    = (state_q == MAC && last) ? {conv(acc_im_q), conv(acc_re_q)} : rij_q;
  end
  assign bus.out_h = h_q;
  assign bus.out_e = e_q;
  assign bus.Rij   = rij_q;
endmodule
